// File: rtl/simulador_pkg.sv
// Shared types and default constants for the bottling-line plant emulator.
package simulador_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int TRAVEL_DEF  = 8;
  localparam int FILL_DEF    = 12;
  localparam int SEAL_DEF    = 4;
  localparam int ROLHAS_DEF  = 20;
  localparam int REFILL_DEF  = 20;

  typedef enum logic [1:0] {
    ESPERA,
    ENCHER,
    TRANSPORTE,
    VEDAR
  } estado_t;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/simulador_linha_temporizador.sv
// Saturating, clearable up-counter; hit flags the cycle whose increment lands on TARGET.
module temporizador #(
  parameter int CNT_W  = 8,
  parameter int TARGET = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [CNT_W-1:0] TGT = CNT_W'(TARGET);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // hit ignores clr so callers may derive clr from it without a loop
  always_comb begin
    hit   = en && (cnt_q != TGT) && ((cnt_q + ONE) == TGT);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != TGT)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/simulador_linha.sv
// Bottling-line plant emulator: turns actuator outputs into PG/CH/RO sensor inputs.
// Define SIMULADOR_ERRO_EN to enable the sticky misuse flag on erro.
module simulador_linha
  import simulador_pkg::*;
#(
  parameter int TRAVEL_CYCLES = TRAVEL_DEF,
  parameter int FILL_CYCLES   = FILL_DEF,
  parameter int SEAL_CYCLES   = SEAL_DEF,
  parameter int ROLHAS_INIT   = ROLHAS_DEF,
  parameter int REFILL        = REFILL_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic M,
  input  logic EV,
  input  logic VE,
  input  logic AD,
  output logic PG,
  output logic CH,
  output logic RO,
  output logic erro
);

  localparam logic [CNT_W:0]   REFILL_W = (CNT_W+1)'(REFILL);
  localparam logic [CNT_W:0]   ONE_W    = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]   MAX_W    = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0] MAX_C    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] INIT_C   = CNT_W'(ROLHAS_INIT);
  localparam logic             RO_INIT  = (ROLHAS_INIT != 0);

  estado_t state_q, state_d;
  logic pg_q, pg_d, ch_q, ch_d, ro_q, ro_d;
  logic ad_q, selada_q, selada_d, refill;
  logic [CNT_W-1:0] rolhas_q, rolhas_d;
  logic [CNT_W:0]   soma;
  logic travel_en, travel_clr, travel_hit;
  logic lvl_en, lvl_clr, lvl_hit;
  logic seal_en, seal_clr, seal_hit;
  logic entra_vedar;

  temporizador #(.CNT_W(CNT_W), .TARGET(TRAVEL_CYCLES)) u_travel (
    .clk(clk), .reset(reset), .clr(travel_clr), .en(travel_en), .hit(travel_hit)
  );

  temporizador #(.CNT_W(CNT_W), .TARGET(FILL_CYCLES)) u_level (
    .clk(clk), .reset(reset), .clr(lvl_clr), .en(lvl_en), .hit(lvl_hit)
  );

  temporizador #(.CNT_W(CNT_W), .TARGET(SEAL_CYCLES)) u_seal (
    .clk(clk), .reset(reset), .clr(seal_clr), .en(seal_en), .hit(seal_hit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ESPERA:     if (travel_hit) state_d = ENCHER;
      ENCHER:     if (M)          state_d = TRANSPORTE;
      TRANSPORTE: if (travel_hit) state_d = VEDAR;
      VEDAR:      if (M)          state_d = ESPERA;
      default:                    state_d = ESPERA;
    endcase
  end

  always_comb begin
    entra_vedar = (state_q == TRANSPORTE) && (state_d == VEDAR);
    travel_en   = M && ((state_q == ESPERA) || (state_q == TRANSPORTE));
    travel_clr  = (state_d != state_q);
    lvl_en      = (state_q == ENCHER) && EV && !M;
    lvl_clr     = (state_q == ESPERA) && (state_d == ENCHER);
    // a sealed bottle never consumes a second stopper, even after another VE burst
    seal_en     = (state_q == VEDAR) && VE && (rolhas_q != '0) && !selada_q;
    seal_clr    = ((state_q == VEDAR) && !VE) || entra_vedar;
    selada_d    = entra_vedar ? 1'b0 : (selada_q | seal_hit);
    refill      = AD && !ad_q;
  end

  // sum in CNT_W+1 bits so refill and consumption net out before saturating
  always_comb begin
    soma = {1'b0, rolhas_q};
    if (refill)   soma = soma + REFILL_W;
    if (seal_hit) soma = soma - ONE_W;
    rolhas_d = (soma > MAX_W) ? MAX_C : soma[CNT_W-1:0];
  end

  always_comb begin
    pg_d = (state_d == ENCHER) || (state_d == VEDAR);
    ch_d = (state_d == VEDAR) ||
           ((state_q == ENCHER) && (state_d == ENCHER) && (ch_q || lvl_hit));
    ro_d = (rolhas_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ESPERA;
      pg_q     <= 1'b0;
      ch_q     <= 1'b0;
      ro_q     <= RO_INIT;
      ad_q     <= 1'b0;
      selada_q <= 1'b0;
      rolhas_q <= INIT_C;
    end else begin
      state_q  <= state_d;
      pg_q     <= pg_d;
      ch_q     <= ch_d;
      ro_q     <= ro_d;
      ad_q     <= AD;
      selada_q <= selada_d;
      rolhas_q <= rolhas_d;
    end
  end

  assign PG = pg_q;
  assign CH = ch_q;
  assign RO = ro_q;

`ifdef SIMULADOR_ERRO_EN
  logic erro_q, erro_d;

  always_comb begin
    erro_d = erro_q | (EV && !pg_q) | (VE && !ro_q) |
             (M && (state_q == ENCHER) && !ch_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      erro_q <= 1'b0;
    end else begin
      erro_q <= erro_d;
    end
  end

  assign erro = erro_q;
`else
  assign erro = 1'b0;
`endif

endmodule

// File: tb/tb_simulador_linha.sv
// Bench for simulador_linha: table of vectors plus bottle sequences, scoreboard queue.
module tb_simulador_linha;

  logic clk, reset, M, EV, VE, AD;
  logic PG, CH, RO, erro;

  simulador_linha dut (
    .clk(clk), .reset(reset), .M(M), .EV(EV), .VE(VE), .AD(AD),
    .PG(PG), .CH(CH), .RO(RO), .erro(erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] tag;
    logic [3:0]  v;
  } exp_t;

  typedef struct {
    logic m, ev, ve, ad;
    int   n;
    logic pg, ch, ro;
  } vec_t;

  exp_t expq[$];
  vec_t tbl[12];
  int   tests = 0;
  int   fails = 0;
  int   tag   = 0;
  int   stock = 0;
  logic er_exp = 1'b0;
  logic er_after_misuse;

  task automatic check_now();
    exp_t e;
    logic [3:0] got;
    e   = expq.pop_front();
    got = {PG, CH, RO, erro};
    tests++;
    if (got !== e.v) begin
      fails++;
      $display("FAIL step%0d PG/CH/RO/erro got %b expected %b", e.tag, got, e.v);
    end
  endtask

  // drive inputs, let n rising edges pass, compare at the following falling edge
  task automatic step(input logic m, input logic ev, input logic ve, input logic ad,
                      input int n, input logic pg, input logic ch, input logic ro);
    exp_t e;
    M = m; EV = ev; VE = ve; AD = ad;
    e.tag = 32'(tag);
    e.v   = {pg, ch, ro, er_exp};
    expq.push_back(e);
    tag++;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check_now();
  endtask

  task automatic add_refill();
    stock = (stock + 20 > 255) ? 255 : stock + 20;
  endtask

  task automatic ad_pulse();
    add_refill();
    step(0, 0, 0, 1, 1, 0, 0, stock != 0);
    step(0, 0, 0, 0, 1, 0, 0, stock != 0);
  endtask

  task automatic to_vedar();
    step(1, 0, 0, 0, 8, 1, 0, stock != 0);
    step(0, 1, 0, 0, 12, 1, 1, stock != 0);
    step(1, 0, 0, 0, 9, 1, 1, stock != 0);
  endtask

  // full bottle cycle; split interrupts sealing, adsim refills on the sealing edge
  task automatic bottle(input bit split, input bit adsim);
    to_vedar();
    if (split) begin
      step(0, 0, 1, 0, 3, 1, 1, 1'b1);
      step(0, 0, 0, 0, 1, 1, 1, 1'b1);
    end
    step(0, 0, 1, 0, 3, 1, 1, 1'b1);
    stock = stock - 1;
    if (adsim) add_refill();
    step(0, 0, 1, adsim, 1, 1, 1, stock != 0);
    step(1, 0, 0, 0, 1, 0, 0, stock != 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 7,  0, 0, 1};
    tbl[1]  = '{1, 0, 0, 0, 1,  1, 0, 1};
    tbl[2]  = '{0, 1, 0, 0, 11, 1, 0, 1};
    tbl[3]  = '{0, 1, 0, 0, 1,  1, 1, 1};
    tbl[4]  = '{0, 1, 0, 0, 3,  1, 1, 1};
    tbl[5]  = '{1, 0, 0, 0, 1,  0, 0, 1};
    tbl[6]  = '{1, 0, 0, 0, 7,  0, 0, 1};
    tbl[7]  = '{1, 0, 0, 0, 1,  1, 1, 1};
    tbl[8]  = '{0, 0, 1, 0, 3,  1, 1, 1};
    tbl[9]  = '{0, 0, 0, 0, 1,  1, 1, 1};
    tbl[10] = '{0, 0, 1, 0, 4,  1, 1, 1};
    tbl[11] = '{1, 0, 0, 0, 1,  0, 0, 1};

`ifdef SIMULADOR_ERRO_EN
    er_after_misuse = 1'b1;
`else
    er_after_misuse = 1'b0;
`endif

    reset = 1'b0; M = 0; EV = 0; VE = 0; AD = 0;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 2, 0, 0, 1);
    reset = 1'b1;
    stock = 20;

    // main flow: travel, fill with saturation, transport, interrupted seal
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].m, tbl[i].ev, tbl[i].ve, tbl[i].ad, tbl[i].n,
           tbl[i].pg, tbl[i].ch, tbl[i].ro);
    end
    stock = 19;

    // deplete; the last bottle checks that an interrupted burst restarts timing
    for (int i = 0; i < 18; i++) bottle(0, 0);
    bottle(1, 0);

    // AD held 5 cycles refills once
    stock = 20;
    step(0, 0, 0, 1, 1, 0, 0, 1);
    step(0, 0, 0, 1, 4, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 19; i++) bottle(0, 0);
    bottle(0, 1);
    for (int i = 0; i < 20; i++) bottle(0, 0);

    // saturation: 13 pulses hit 255, drop to 250, one more pulse saturates again
    for (int i = 0; i < 13; i++) ad_pulse();
    for (int i = 0; i < 5; i++) bottle(0, 0);
    ad_pulse();
    for (int i = 0; i < 255; i++) bottle(0, 0);

    // misuse: valve open with no bottle present
    ad_pulse();
    er_exp = er_after_misuse;
    step(0, 1, 0, 0, 1, 0, 0, 1);
    bottle(0, 0);

    // asynchronous reset while sealing with the timer at 2
    to_vedar();
    step(0, 0, 1, 0, 2, 1, 1, 1);
    M = 0; EV = 0; VE = 0; AD = 0;
    #2 reset = 1'b0;
    #1;
    er_exp = 1'b0;
    begin
      exp_t e;
      e.tag = 32'(tag);
      e.v   = {1'b0, 1'b0, 1'b1, 1'b0};
      expq.push_back(e);
      tag++;
      check_now();
    end
    @(negedge clk);
    reset = 1'b1;
    stock = 20;
    for (int i = 0; i < 20; i++) bottle(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
